lcd_text_ctrl: RTL and testbench

//  Parametrised HD44780 4-bit character-LCD controller for the Spartan-3E starter-board LCD.

---
 rtl/lcd_pkg.sv | 41 ++++
 rtl/lcd_text_ctrl_if.sv | 11 +
 rtl/lcd_nibble_tx.sv | 92 +++++++++
 rtl/lcd_text_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_lcd_text_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and the DDRAM row-base lookup
// for the HD44780 text controller.
package lcd_pkg;

  localparam logic [7:0] FUNC_SET  = 8'h28;
  localparam logic [7:0] ENTRY     = 8'h06;
  localparam logic [7:0] DISP_ON   = 8'h0C;
  localparam logic [7:0] CLEAR     = 8'h01;
  localparam logic [7:0] SET_DDRAM = 8'h80;

  localparam int CNT_W = 20;

  typedef enum logic [3:0] {
    ST_PWRUP,
    ST_LOAD,
    ST_HI_START,
    ST_HI_BUSY,
    ST_GAP,
    ST_LO_START,
    ST_LO_BUSY,
    ST_WAIT,
    ST_ADV
  } ctrl_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SETUP,
    TX_PULSE,
    TX_HOLD
  } tx_phase_t;

  function automatic logic [7:0] row_base(input logic [1:0] r);
    case (r)
      2'd0:    return 8'h00;
      2'd1:    return 8'h40;
      2'd2:    return 8'h14;
      default: return 8'h54;
    endcase
  endfunction

endpackage

// File: rtl/lcd_text_ctrl_if.sv
// Host-side character buffer write port.
interface lcd_text_ctrl_if #(
  parameter int AW = 6
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/lcd_nibble_tx.sv
// Sends one nibble to the LCD: 2 cycles setup, T_E cycles of E high,
// 2 cycles hold, then a one-cycle done pulse. rs/d stay put until the next start.
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int T_E = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] nib,
  input  logic       rs,
  output logic       lcd_e,
  output logic [3:0] lcd_d,
  output logic       lcd_rs,
  output logic       done
);

  localparam int CW = $clog2(T_E + 2);

  tx_phase_t     phase, phase_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          e_next;
  logic          done_next;
  logic          latch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase  <= TX_IDLE;
      cnt    <= '0;
      lcd_e  <= 1'b0;
      lcd_d  <= 4'h0;
      lcd_rs <= 1'b0;
      done   <= 1'b0;
    end else begin
      phase <= phase_next;
      cnt   <= cnt_next;
      lcd_e <= e_next;
      done  <= done_next;
      if (latch) begin
        lcd_d  <= nib;
        lcd_rs <= rs;
      end
    end
  end

  // E is registered so an async reset pulls it low in the same cycle.
  always_comb begin
    phase_next = phase;
    cnt_next   = cnt;
    e_next     = 1'b0;
    done_next  = 1'b0;
    latch      = 1'b0;
    unique case (phase)
      TX_IDLE: begin
        if (start) begin
          latch      = 1'b1;
          phase_next = TX_SETUP;
          cnt_next   = CW'(1);
        end
      end
      TX_SETUP: begin
        if (cnt == '0) begin
          phase_next = TX_PULSE;
          cnt_next   = CW'(T_E - 1);
          e_next     = 1'b1;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      TX_PULSE: begin
        if (cnt == '0) begin
          phase_next = TX_HOLD;
          cnt_next   = CW'(1);
        end else begin
          cnt_next = cnt - 1'b1;
          e_next   = 1'b1;
        end
      end
      TX_HOLD: begin
        if (cnt == '0) begin
          phase_next = TX_IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: phase_next = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/lcd_text_ctrl.sv
// HD44780 4-bit controller: power-on init, then endless refresh of a
// ROWS x COLS character buffer that the host may rewrite at any time.
module lcd_text_ctrl
  import lcd_pkg::*;
#(
  parameter int ROWS    = 2,
  parameter int COLS    = 16,
  parameter int T_PWRUP = 750000,
  parameter int T_INIT1 = 205000,
  parameter int T_INIT2 = 5000,
  parameter int T_CMD   = 2000,
  parameter int T_CLR   = 82000,
  parameter int T_NIB   = 50,
  parameter int T_E     = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lcd_text_ctrl_if.slave        wr,
  output logic                  ready,
  output logic                  frame,
  output logic                  lcd_rs,
  output logic                  lcd_rw,
  output logic                  lcd_e,
  output logic [3:0]            lcd_d,
  output logic                  sf_ce0
);

  localparam int NCHARS = ROWS * COLS;
  // One spare code point so indices at or beyond NCHARS reach the range check.
  localparam int AW = $clog2(NCHARS + 1);
  localparam int IW = (NCHARS > 1) ? $clog2(NCHARS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  ctrl_state_t       state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_val;
  logic              cnt_load;
  logic              tx_start, tx_done;
  logic [3:0]        tx_nib;

  logic [7:0]        char_buf [NCHARS];
  logic [IW-1:0]     rd_idx;

  logic [7:0]        cur_byte, ld_byte;
  logic              cur_rs, ld_rs, ld_single;
  logic [CNT_W-1:0]  cur_wait, ld_wait;
  logic [2:0]        init_step;
  logic              in_cmd;
  logic [RW-1:0]     row;
  logic [CW-1:0]     col;

  assign lcd_rw = 1'b0;
  assign sf_ce0 = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCHARS; i++) char_buf[i] <= 8'h20;
    end else if (wr.wr_en && (wr.wr_addr < AW'(NCHARS))) begin
      char_buf[wr.wr_addr[IW-1:0]] <= wr.wr_data;
    end
  end

  assign rd_idx = IW'(row) * IW'(COLS) + IW'(col);

  // What the next transfer will be; latched into cur_* at the start of each byte.
  always_comb begin
    ld_byte   = 8'h00;
    ld_rs     = 1'b0;
    ld_single = 1'b0;
    ld_wait   = CNT_W'(T_CMD);
    if (!ready) begin
      unique case (init_step)
        3'd0: begin ld_byte = 8'h03; ld_single = 1'b1; ld_wait = CNT_W'(T_INIT1); end
        3'd1: begin ld_byte = 8'h03; ld_single = 1'b1; ld_wait = CNT_W'(T_INIT2); end
        3'd2: begin ld_byte = 8'h03; ld_single = 1'b1; end
        3'd3: begin ld_byte = 8'h02; ld_single = 1'b1; end
        3'd4: ld_byte = FUNC_SET;
        3'd5: ld_byte = ENTRY;
        3'd6: ld_byte = DISP_ON;
        default: begin ld_byte = CLEAR; ld_wait = CNT_W'(T_CLR); end
      endcase
    end else if (in_cmd) begin
      ld_byte = SET_DDRAM | row_base(2'(row));
    end else begin
      ld_byte = char_buf[rd_idx];
      ld_rs   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_PWRUP;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx_start   = 1'b0;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    unique case (state)
      ST_PWRUP:    if (cnt <= CNT_W'(1)) state_next = ST_LOAD;
      ST_LOAD:     state_next = ld_single ? ST_LO_START : ST_HI_START;
      ST_HI_START: begin tx_start = 1'b1; state_next = ST_HI_BUSY; end
      ST_HI_BUSY: begin
        if (tx_done) begin
          cnt_load   = 1'b1;
          cnt_val    = CNT_W'(T_NIB);
          state_next = ST_GAP;
        end
      end
      ST_GAP:      if (cnt <= CNT_W'(1)) state_next = ST_LO_START;
      ST_LO_START: begin tx_start = 1'b1; state_next = ST_LO_BUSY; end
      ST_LO_BUSY: begin
        if (tx_done) begin
          cnt_load   = 1'b1;
          cnt_val    = cur_wait;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT:     if (cnt <= CNT_W'(1)) state_next = ST_ADV;
      ST_ADV:      state_next = ST_LOAD;
      default:     state_next = ST_PWRUP;
    endcase
  end

  // Shared down-counter: a wait state loaded with N lasts exactly N cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= CNT_W'(T_PWRUP);
    else if (cnt_load)       cnt <= cnt_val;
    else if (cnt != '0)      cnt <= cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_byte  <= 8'h00;
      cur_rs    <= 1'b0;
      cur_wait  <= '0;
      init_step <= 3'd0;
      ready     <= 1'b0;
      in_cmd    <= 1'b1;
      row       <= '0;
      col       <= '0;
      frame     <= 1'b0;
    end else begin
      frame <= 1'b0;
      if (state == ST_LOAD) begin
        cur_byte <= ld_byte;
        cur_rs   <= ld_rs;
        cur_wait <= ld_wait;
      end
      if (state == ST_ADV) begin
        if (!ready) begin
          if (init_step == 3'd7) ready <= 1'b1;
          else                   init_step <= init_step + 1'b1;
        end else if (in_cmd) begin
          in_cmd <= 1'b0;
          col    <= '0;
        end else if (col == CW'(COLS - 1)) begin
          col    <= '0;
          in_cmd <= 1'b1;
          if (row == RW'(ROWS - 1)) begin
            row   <= '0;
            frame <= 1'b1;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  assign tx_nib = (state == ST_HI_START) ? cur_byte[7:4] : cur_byte[3:0];

  lcd_nibble_tx #(
    .T_E(T_E)
  ) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (tx_start),
    .nib    (tx_nib),
    .rs     (cur_rs),
    .lcd_e  (lcd_e),
    .lcd_d  (lcd_d),
    .lcd_rs (lcd_rs),
    .done   (tx_done)
  );

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Scoreboard bench: expected nibbles are queued as stimulus is applied and
// compared against nibbles captured from the LCD pins on each E pulse.
module tb_lcd_text_ctrl;

  localparam int ROWS   = 2;
  localparam int COLS   = 16;
  localparam int NCHARS = ROWS * COLS;
  localparam int AW     = $clog2(NCHARS + 1);

  typedef struct {
    logic       rs;
    logic [3:0] d;
    int         ehigh;
  } nib_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ready, frame, lcd_rs, lcd_rw, lcd_e, sf_ce0;
  logic [3:0] lcd_d;

  lcd_text_ctrl_if #(.AW(AW)) bus ();

  lcd_text_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .T_PWRUP(20), .T_INIT1(10), .T_INIT2(5),
    .T_CMD(4), .T_CLR(8), .T_NIB(2), .T_E(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr(bus), .ready(ready), .frame(frame),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_d(lcd_d), .sf_ce0(sf_ce0)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  nib_t       obs_q[$];
  logic [4:0] exp_q[$];
  logic [7:0] mem [NCHARS];

  logic       e_prev = 1'b0;
  logic       frame_prev = 1'b0;
  logic [4:0] h1 = '0, h2 = '0;
  nib_t       cur;
  int         frame_pulses = 0, frame_hi = 0, pin_err = 0, stab_err = 0;

  // Pin monitor: one nibble captured per E pulse, plus pin-level sanity counters.
  always @(negedge clk) begin
    if (sf_ce0 !== 1'b1 || lcd_rw !== 1'b0) pin_err++;
    if (!rst_n) begin
      e_prev     = 1'b0;
      frame_prev = 1'b0;
    end else begin
      if (frame === 1'b1) begin
        frame_hi++;
        if (!frame_prev) frame_pulses++;
      end
      if (lcd_e === 1'b1 && !e_prev) begin
        cur.rs = lcd_rs; cur.d = lcd_d; cur.ehigh = 1;
        if (h1 !== {lcd_rs, lcd_d} || h2 !== {lcd_rs, lcd_d}) stab_err++;
      end else if (lcd_e === 1'b1) begin
        cur.ehigh++;
        if ({lcd_rs, lcd_d} !== {cur.rs, cur.d}) stab_err++;
      end else if (e_prev) begin
        if ({lcd_rs, lcd_d} !== {cur.rs, cur.d}) stab_err++;
        obs_q.push_back(cur);
      end
      e_prev     = lcd_e;
      frame_prev = frame;
      h2         = h1;
      h1         = {lcd_rs, lcd_d};
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no end, required end of tests");
    $fatal(1, "watchdog");
  end

  task automatic push_nib(input logic rs, input logic [3:0] d);
    exp_q.push_back({rs, d});
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] b);
    push_nib(rs, b[7:4]);
    push_nib(rs, b[3:0]);
  endtask

  task automatic push_frame();
    logic [7:0] base [2];
    base[0] = 8'h00;
    base[1] = 8'h40;
    for (int r = 0; r < ROWS; r++) begin
      push_byte(1'b0, 8'h80 | base[r]);
      for (int c = 0; c < COLS; c++) push_byte(1'b1, mem[r*COLS + c]);
    end
  endtask

  task automatic wait_obs(output bit ok);
    int n = 0;
    while (obs_q.size() == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    ok = (obs_q.size() != 0);
  endtask

  task automatic wait_frame(output bit ok);
    int start = frame_pulses;
    int n = 0;
    while (frame_pulses == start && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = (frame_pulses != start);
  endtask

  task automatic write_char(input int addr, input logic [7:0] data);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(addr);
    bus.wr_data = data;
    @(negedge clk);
    bus.wr_en = 1'b0;
    if (addr < NCHARS) mem[addr] = data;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NCHARS; i++) mem[i] = 8'h20;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (lcd_e  !== 1'b0) begin errors++; $display("[TB] FAIL reset_e: got %b want 0", lcd_e); end
    checks++; if (lcd_rs !== 1'b0) begin errors++; $display("[TB] FAIL reset_rs: got %b want 0", lcd_rs); end
    checks++; if (lcd_rw !== 1'b0) begin errors++; $display("[TB] FAIL reset_rw: got %b want 0", lcd_rw); end
    checks++; if (lcd_d  !== 4'h0) begin errors++; $display("[TB] FAIL reset_d: got %h want 0", lcd_d); end
    checks++; if (sf_ce0 !== 1'b1) begin errors++; $display("[TB] FAIL reset_ce0: got %b want 1", sf_ce0); end
    checks++; if (ready  !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b want 0", ready); end
    checks++; if (frame  !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame: got %b want 0", frame); end
    rst_n = 1'b1;
  endtask

  task automatic test_init();
    nib_t o; logic [4:0] ev; bit ok;
    obs_q.delete(); exp_q.delete();
    pin_err = 0; stab_err = 0;
    push_nib(1'b0, 4'h3); push_nib(1'b0, 4'h3); push_nib(1'b0, 4'h3); push_nib(1'b0, 4'h2);
    push_byte(1'b0, 8'h28); push_byte(1'b0, 8'h06); push_byte(1'b0, 8'h0C); push_byte(1'b0, 8'h01);
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL init_ready: got %b want 0", ready); end
    while (exp_q.size() != 0) begin
      wait_obs(ok);
      if (!ok) begin
        checks++; errors++;
        $display("[TB] FAIL init_timeout: got no nibble, want %0d more", exp_q.size());
        exp_q.delete();
      end else begin
        o = obs_q.pop_front(); ev = exp_q.pop_front(); checks++;
        if ({o.rs, o.d} !== ev || o.ehigh !== 3) begin
          errors++;
          $display("[TB] FAIL init_nibble: got rs=%b d=%h e=%0d want rs=%b d=%h e=3", o.rs, o.d, o.ehigh, ev[4], ev[3:0]);
        end
      end
    end
    checks++; if (pin_err  !== 0) begin errors++; $display("[TB] FAIL init_pins: got %0d rw/ce0 faults want 0", pin_err); end
    checks++; if (stab_err !== 0) begin errors++; $display("[TB] FAIL init_stable: got %0d setup/hold faults want 0", stab_err); end
  endtask

  task automatic test_refresh_default();
    nib_t o; logic [4:0] ev; bit ok; int hi0;
    push_frame();
    while (exp_q.size() != 0) begin
      wait_obs(ok);
      if (!ok) begin
        checks++; errors++;
        $display("[TB] FAIL refresh_timeout: got no nibble, want %0d more", exp_q.size());
        exp_q.delete();
      end else begin
        o = obs_q.pop_front(); ev = exp_q.pop_front(); checks++;
        if ({o.rs, o.d} !== ev || o.ehigh !== 3) begin
          errors++;
          $display("[TB] FAIL refresh_nibble: got rs=%b d=%h e=%0d want rs=%b d=%h e=3", o.rs, o.d, o.ehigh, ev[4], ev[3:0]);
        end
      end
    end
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL refresh_ready: got %b want 1", ready); end
    hi0 = frame_hi;
    wait_frame(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL refresh_frame: got no pulse want 1"); end
    @(negedge clk);
    checks++; if (frame_hi - hi0 !== 1) begin errors++; $display("[TB] FAIL refresh_frame_width: got %0d cycles want 1", frame_hi - hi0); end
  endtask

  task automatic test_write();
    nib_t o; logic [4:0] ev; bit ok;
    obs_q.delete();
    write_char(0, 8'h48);
    write_char(17, 8'h69);
    push_frame();
    while (exp_q.size() != 0) begin
      wait_obs(ok);
      if (!ok) begin
        checks++; errors++;
        $display("[TB] FAIL write_timeout: got no nibble, want %0d more", exp_q.size());
        exp_q.delete();
      end else begin
        o = obs_q.pop_front(); ev = exp_q.pop_front(); checks++;
        if ({o.rs, o.d} !== ev) begin
          errors++;
          $display("[TB] FAIL write_nibble: got rs=%b d=%h want rs=%b d=%h", o.rs, o.d, ev[4], ev[3:0]);
        end
      end
    end
    wait_frame(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL write_frame: got no pulse want 1"); end
  endtask

  task automatic test_inflight();
    nib_t o; logic [4:0] ev; bit ok; int n;
    obs_q.delete();
    for (int pass = 0; pass < 2; pass++) begin
      push_frame();
      if (pass == 0) begin
        n = 0;
        while (obs_q.size() < 13 && n < 600) begin @(negedge clk); n++; end
        checks++;
        if (obs_q.size() < 13) begin errors++; $display("[TB] FAIL inflight_reach: got %0d nibbles want 13", obs_q.size()); end
        write_char(5, 8'h41);
      end
      while (exp_q.size() != 0) begin
        wait_obs(ok);
        if (!ok) begin
          checks++; errors++;
          $display("[TB] FAIL inflight_timeout: got no nibble, want %0d more", exp_q.size());
          exp_q.delete();
        end else begin
          o = obs_q.pop_front(); ev = exp_q.pop_front(); checks++;
          if ({o.rs, o.d} !== ev) begin
            errors++;
            $display("[TB] FAIL inflight_nibble pass %0d: got rs=%b d=%h want rs=%b d=%h", pass, o.rs, o.d, ev[4], ev[3:0]);
          end
        end
      end
      wait_frame(ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL inflight_frame: got no pulse want 1"); end
    end
  endtask

  task automatic test_out_of_range();
    nib_t o; logic [4:0] ev; bit ok;
    obs_q.delete();
    write_char(32, 8'h58);
    push_frame();
    while (exp_q.size() != 0) begin
      wait_obs(ok);
      if (!ok) begin
        checks++; errors++;
        $display("[TB] FAIL oor_timeout: got no nibble, want %0d more", exp_q.size());
        exp_q.delete();
      end else begin
        o = obs_q.pop_front(); ev = exp_q.pop_front(); checks++;
        if ({o.rs, o.d} !== ev) begin
          errors++;
          $display("[TB] FAIL oor_nibble: got rs=%b d=%h want rs=%b d=%h", o.rs, o.d, ev[4], ev[3:0]);
        end
      end
    end
    wait_frame(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL oor_frame: got no pulse want 1"); end
  endtask

  task automatic test_reset_midframe();
    int n;
    obs_q.delete();
    n = 0;
    while (obs_q.size() < 3 && n < 300) begin @(negedge clk); n++; end
    n = 0;
    while (lcd_e !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (lcd_e !== 1'b1 || lcd_rs !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_lownib: got e=%b rs=%b want e=1 rs=1", lcd_e, lcd_rs);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (lcd_e !== 1'b0) begin errors++; $display("[TB] FAIL mid_e_drop: got %b want 0", lcd_e); end
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_ready: got %b want 0", ready); end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NCHARS; i++) mem[i] = 8'h20;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_init();
    test_refresh_default();
    test_write();
    test_inflight();
    test_out_of_range();
    test_reset_midframe();
    test_init();
    test_refresh_default();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
